wb_vector_regfile: RTL and testbench
====================================

# wb_vector_regfile

Writeback-side consumer of the MEM/WB pipeline register. It selects the 128-bit writeback value (data memory or ALU result), commits it to a 32-entry × 128-bit vector register file, and serves two registered read ports to decode with same-cycle write bypass. A per-register pending-write scoreboard is set at issue and cleared at writeback, and drives the decode stall signal. A saturating counter records committed writes.

## Interface
- `DATA_W`, 128, register and datapath width
- `NREGS`, 32, register count; register 0 is hardwired to zero
- `CNT_W`, 16, width of the commit counter
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `wb_dm_in` in DATA_W: memory load data from MEM/WB
- `wb_alu_in` in DATA_W: ALU result from MEM/WB
- `wb_rd_in` in 5: destination register from MEM/WB
- `wb_regwrite_in` in 1: write enable from MEM/WB
- `wb_memtoreg_in` in 1: 1 selects `wb_dm_in`, 0 selects `wb_alu_in`
- `rs1_addr`, `rs2_addr` in 5: decode read addresses
- `rd_en` in 1: capture read data this cycle
- `rs1_data`, `rs2_data` out DATA_W: registered read data
- `issue_valid` in 1: an instruction leaves decode this cycle
- `issue_rd` in 5: its destination
- `issue_regwrite` in 1: it will write `issue_rd`
- `stall` out 1: combinational RAW hazard on rs1/rs2
- `busy_vec` out NREGS: registered scoreboard
- `commit_cnt` out CNT_W: registered count of committed writes

## Operation
- **Writeback value:** `wb_val = wb_memtoreg_in ? wb_dm_in : wb_alu_in`.
- **Commit:** a commit occurs when `wb_regwrite_in && wb_rd_in != 0`. On a commit, `reg[wb_rd_in] <= wb_val`.
  - Writes to register 0 are discarded and are not counted.
  - Register 0 always reads zero.
- **Read:** when `rd_en`, `rsN_data <= (commit && wb_rd_in == rsN_addr) ? wb_val : reg[rsN_addr]`.
  - `rsN_addr == 0` yields zero.
  - When `rd_en == 0`, `rsN_data` holds its value.
- **Scoreboard set:** `busy[issue_rd]` is set when `issue_valid && issue_regwrite && issue_rd != 0`.
- **Scoreboard clear:** `busy[wb_rd_in]` is cleared on a commit.
- **Set and clear on the same register in the same cycle:** set wins, because a newer producer is in flight.
- **`busy[0]`:** always 0.
- **Stall:**
  - `stall = (busy_eff[rs1_addr] && rs1_addr != 0) || (busy_eff[rs2_addr] && rs2_addr != 0)`.
  - `busy_eff` is `busy_vec` with the bit being cleared this cycle by a commit removed, since the bypass covers it.
  - `stall` ignores `rd_en`.
- **Counter:** `commit_cnt` increments by 1 per commit and saturates at 2^CNT_W − 1. It does not wrap.
- **Reset:** clears all registers to zero in a single cycle.

## Timing
- **Reset values:**
  - `rs1_data = rs2_data = 0`
  - `busy_vec = 0`
  - `commit_cnt = 0`
  - all register contents 0
  - `stall = 0` while `busy_vec == 0`
- **Reset mid-operation:** reset takes priority over every concurrent commit, issue or read in that cycle. Nothing from that cycle is retained.
- **Write latency:** a commit at edge N is visible through a normal read at edge N+1. Through the bypass, it is visible at edge N itself.
- **Read latency:** 1 cycle from `rd_en` to `rsN_data`.
- **Issue-to-busy latency:** issue at edge N sets the bit visible in `busy_vec` and `stall` after edge N. The issuing instruction is never stalled by its own destination.
- **Clear timing:** a commit to register r deasserts `stall` for r combinationally in the commit cycle, so a dependent read captured at that edge gets `wb_val`.
- **Saturation:** at max value, further commits leave `commit_cnt` unchanged.

## Test plan
- **Reset flush:** write r5 = 0xDEAD…BEEF, pulse `reset` for one cycle, then read r5. Expect `rs1_data = 0`, `busy_vec = 0`, `commit_cnt = 0`.
- **Writeback mux and read:**
  - `wb_rd_in = 3`, `wb_memtoreg_in = 1`, `wb_dm_in = 0x11…11`, `wb_alu_in = 0x22…22`.
  - Next cycle, read rs1 = 3. Expect `0x11…11`.
  - Repeat with `wb_memtoreg_in = 0`. Expect `0x22…22`.
  - `commit_cnt` = 2 after both commits.
- **Register 0:** commit r0 = all-ones, then read rs1 = rs2 = 0. Expect 0 on both, `commit_cnt` unchanged, `busy_vec[0] = 0`.
- **Bypass and scoreboard:**
  - Issue rd = 7 → `busy_vec[7] = 1`.
  - `rs1_addr = 7` → `stall = 1`.
  - In the cycle where the commit to r7 = 0xABC occurs with `rd_en = 1`: `stall = 0`, and `rs1_data = 0xABC` at that edge.
  - `busy_vec[7] = 0` afterwards.
- **Same-cycle set and clear:** with r9 busy, commit r9 and issue rd = 9 in the same cycle. Expect `busy_vec[9] = 1` and `stall = 1` next cycle for `rs2_addr = 9`.
- **Saturation (CNT_W = 4 build):** perform 20 commits. Expect `commit_cnt = 15`, holding.

Source files
------------

// File: rtl/wb_vector_regfile.sv
// Writeback stage: selects the writeback value and commits it to a 32x128 vector register file.
// Also provides two bypassed registered read ports, a pending-write scoreboard and a saturating commit counter.
module wb_vector_regfile #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wb_dm_in,
  input  logic [DATA_W-1:0] wb_alu_in,
  input  logic [4:0]        wb_rd_in,
  input  logic              wb_regwrite_in,
  input  logic              wb_memtoreg_in,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic              issue_regwrite,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec,
  output logic [CNT_W-1:0]  commit_cnt
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [NREGS-1:0]  r_busy;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_wb_val;
  logic              w_commit;
  logic              w_issue_set;
  logic [NREGS-1:0]  w_clr_mask;
  logic [NREGS-1:0]  w_set_mask;
  logic [NREGS-1:0]  w_busy_eff;
  logic [NREGS-1:0]  w_busy_nxt;
  logic [DATA_W-1:0] w_rs1_nxt;
  logic [DATA_W-1:0] w_rs2_nxt;

  // Writeback select, commit qualification and scoreboard next state (a new issue beats a clear)
  always_comb begin
    w_wb_val    = wb_memtoreg_in ? wb_dm_in : wb_alu_in;
    w_commit    = wb_regwrite_in && (wb_rd_in != 5'd0);
    w_issue_set = issue_valid && issue_regwrite && (issue_rd != 5'd0);
    w_clr_mask  = '0;
    w_set_mask  = '0;
    if (w_commit)    w_clr_mask[wb_rd_in] = 1'b1;
    if (w_issue_set) w_set_mask[issue_rd] = 1'b1;
    w_busy_eff    = r_busy & ~w_clr_mask;
    w_busy_nxt    = w_busy_eff | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  // Read ports with same-cycle bypass of the committing value
  always_comb begin
    w_rs1_nxt = '0;
    w_rs2_nxt = '0;
    if (rs1_addr != 5'd0) begin
      w_rs1_nxt = (w_commit && (wb_rd_in == rs1_addr)) ? w_wb_val : r_regs[rs1_addr];
    end
    if (rs2_addr != 5'd0) begin
      w_rs2_nxt = (w_commit && (wb_rd_in == rs2_addr)) ? w_wb_val : r_regs[rs2_addr];
    end
  end

  // A register being committed this cycle is not a hazard: the bypass supplies it
  assign stall = (w_busy_eff[rs1_addr] && (rs1_addr != 5'd0)) ||
                 (w_busy_eff[rs2_addr] && (rs2_addr != 5'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_busy     <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_commit) begin
        r_regs[wb_rd_in] <= w_wb_val;
      end
      if (rd_en) begin
        r_rs1_data <= w_rs1_nxt;
        r_rs2_data <= w_rs2_nxt;
      end
      r_busy <= w_busy_nxt;
      if (w_commit && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign rs1_data   = r_rs1_data;
  assign rs2_data   = r_rs2_data;
  assign busy_vec   = r_busy;
  assign commit_cnt = r_cnt;

endmodule

// File: tb/tb_wb_vector_regfile.sv
// Bench for wb_vector_regfile: directed vector table, then randomized traffic against a reference model.
// A second instance built with a 4-bit counter exercises saturation.
module tb_wb_vector_regfile;

  localparam logic [127:0] Z     = 128'h0;
  localparam logic [127:0] DEAD  = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
  localparam logic [127:0] ONES1 = {32{4'h1}};
  localparam logic [127:0] TWOS  = {32{4'h2}};
  localparam logic [127:0] ALL1  = {128{1'b1}};
  localparam logic [127:0] ABC   = 128'hABC;
  localparam logic [127:0] H55   = 128'h55;
  localparam logic [127:0] H66   = 128'h66;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] wb_dm_in, wb_alu_in;
  logic [4:0]   wb_rd_in;
  logic         wb_regwrite_in, wb_memtoreg_in;
  logic [4:0]   rs1_addr, rs2_addr;
  logic         rd_en;
  logic         issue_valid, issue_regwrite;
  logic [4:0]   issue_rd;
  logic [127:0] rs1_data, rs2_data, rs1_data_s, rs2_data_s;
  logic         stall, stall_s;
  logic [31:0]  busy_vec, busy_vec_s;
  logic [15:0]  commit_cnt;
  logic [3:0]   commit_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_vector_regfile u_dut (
    .clk(clk), .reset(reset), .wb_dm_in(wb_dm_in), .wb_alu_in(wb_alu_in),
    .wb_rd_in(wb_rd_in), .wb_regwrite_in(wb_regwrite_in), .wb_memtoreg_in(wb_memtoreg_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_en(rd_en),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_regwrite(issue_regwrite), .stall(stall),
    .busy_vec(busy_vec), .commit_cnt(commit_cnt)
  );

  wb_vector_regfile #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .wb_dm_in(wb_dm_in), .wb_alu_in(wb_alu_in),
    .wb_rd_in(wb_rd_in), .wb_regwrite_in(wb_regwrite_in), .wb_memtoreg_in(wb_memtoreg_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_en(rd_en),
    .rs1_data(rs1_data_s), .rs2_data(rs2_data_s), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_regwrite(issue_regwrite), .stall(stall_s),
    .busy_vec(busy_vec_s), .commit_cnt(commit_cnt_s)
  );

  typedef struct {
    logic         rst, rw, m2r;
    logic [4:0]   wrd;
    logic [127:0] dm, alu;
    logic [4:0]   a1, a2;
    logic         ren, iv;
    logic [4:0]   ird;
    logic         irw;
    logic         e_stall;
    logic [127:0] e_rs1, e_rs2;
    logic [31:0]  e_busy;
    logic [15:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, rw, m2r, input logic [4:0] wrd,
                              input logic [127:0] dm, alu, input logic [4:0] a1, a2,
                              input logic ren, iv, input logic [4:0] ird, input logic irw,
                              input logic e_stall, input logic [127:0] e_rs1, e_rs2,
                              input logic [31:0] e_busy, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.rw = rw; v.m2r = m2r; v.wrd = wrd; v.dm = dm; v.alu = alu;
    v.a1 = a1; v.a2 = a2; v.ren = ren; v.iv = iv; v.ird = ird; v.irw = irw;
    v.e_stall = e_stall; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_busy = e_busy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; wb_regwrite_in = v.rw; wb_memtoreg_in = v.m2r; wb_rd_in = v.wrd;
    wb_dm_in = v.dm; wb_alu_in = v.alu; rs1_addr = v.a1; rs2_addr = v.a2; rd_en = v.ren;
    issue_valid = v.iv; issue_rd = v.ird; issue_regwrite = v.irw;
  endtask

  // Reference model state
  logic [127:0] m_regs [32];
  logic [31:0]  m_busy;
  int           m_cnt, m_cnt4;
  logic [127:0] m_rs1, m_rs2;

  function automatic logic [127:0] m_read(input logic [4:0] a, input logic commit,
                                          input logic [127:0] val);
    if (a == 5'd0) return Z;
    if (commit && wb_rd_in == a) return val;
    return m_regs[a];
  endfunction

  // Check stall against current inputs, advance the model one edge, then check registered outputs
  task automatic model_step();
    logic         commit;
    logic [127:0] val;
    logic         e_stall;
    commit  = wb_regwrite_in && (wb_rd_in != 5'd0);
    val     = wb_memtoreg_in ? wb_dm_in : wb_alu_in;
    e_stall = 1'b0;
    if (rs1_addr != 0 && m_busy[rs1_addr] && !(commit && wb_rd_in == rs1_addr)) e_stall = 1'b1;
    if (rs2_addr != 0 && m_busy[rs2_addr] && !(commit && wb_rd_in == rs2_addr)) e_stall = 1'b1;
    #1;
    chk("rand_stall", 128'(stall), 128'(e_stall));
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = Z;
      m_busy = '0; m_cnt = 0; m_cnt4 = 0; m_rs1 = Z; m_rs2 = Z;
    end else begin
      if (rd_en) begin
        m_rs1 = m_read(rs1_addr, commit, val);
        m_rs2 = m_read(rs2_addr, commit, val);
      end
      if (commit) begin
        m_regs[wb_rd_in] = val;
        m_busy[wb_rd_in] = 1'b0;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (issue_valid && issue_regwrite && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    end
    @(posedge clk); #1;
    chk("rand_rs1", rs1_data, m_rs1);
    chk("rand_rs2", rs2_data, m_rs2);
    chk("rand_busy", 128'(busy_vec), 128'(m_busy));
    chk("rand_cnt", 128'(commit_cnt), 128'(m_cnt));
    chk("rand_cnt4", 128'(commit_cnt_s), 128'(m_cnt4));
  endtask

  vec_t vecs [18];
  vec_t idle;

  initial begin
    idle = mk(0,0,0,0,Z,Z, 0,0,0, 0,0,0, 0,Z,Z,0,0);
    vecs[0]  = mk(0,1,1,5,DEAD,Z,   0,0,0, 0,0,0,  0,Z,Z,     32'h0,  1);
    vecs[1]  = mk(0,0,0,0,Z,Z,      5,0,1, 0,0,0,  0,DEAD,Z,  32'h0,  1);
    vecs[2]  = mk(1,1,0,5,Z,ALL1,   5,0,1, 1,4,1,  0,Z,Z,     32'h0,  0);
    vecs[3]  = mk(0,0,0,0,Z,Z,      5,0,1, 0,0,0,  0,Z,Z,     32'h0,  0);
    vecs[4]  = mk(0,1,1,3,ONES1,TWOS,0,0,0,0,0,0,  0,Z,Z,     32'h0,  1);
    vecs[5]  = mk(0,0,0,0,Z,Z,      3,0,1, 0,0,0,  0,ONES1,Z, 32'h0,  1);
    vecs[6]  = mk(0,1,0,3,ONES1,TWOS,0,0,0,0,0,0,  0,ONES1,Z, 32'h0,  2);
    vecs[7]  = mk(0,0,0,0,Z,Z,      3,0,1, 0,0,0,  0,TWOS,Z,  32'h0,  2);
    vecs[8]  = mk(0,1,1,0,ALL1,ALL1,0,0,1, 0,0,0,  0,Z,Z,     32'h0,  2);
    vecs[9]  = mk(0,0,0,0,Z,Z,      3,0,1, 1,0,1,  0,TWOS,Z,  32'h0,  2);
    vecs[10] = mk(0,0,0,0,Z,Z,      7,0,0, 1,7,1,  0,TWOS,Z,  32'h80, 2);
    vecs[11] = mk(0,0,0,0,Z,Z,      7,0,0, 0,0,0,  1,TWOS,Z,  32'h80, 2);
    vecs[12] = mk(0,1,0,7,Z,ABC,    7,0,1, 0,0,0,  0,ABC,Z,   32'h0,  3);
    vecs[13] = mk(0,0,0,0,Z,Z,      7,3,1, 0,0,0,  0,ABC,TWOS,32'h0,  3);
    vecs[14] = mk(0,0,0,0,Z,Z,      0,9,0, 1,9,1,  0,ABC,TWOS,32'h200,3);
    vecs[15] = mk(0,1,0,9,Z,H55,    0,9,1, 1,9,1,  0,Z,H55,   32'h200,4);
    vecs[16] = mk(0,0,0,0,Z,Z,      0,9,0, 0,0,0,  1,Z,H55,   32'h200,4);
    vecs[17] = mk(0,1,0,9,Z,H66,    9,0,0, 1,10,0, 0,Z,H55,   32'h0,  5);

    // Initial reset
    drive(idle);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rs1", rs1_data, Z);
    chk("reset_rs2", rs2_data, Z);
    chk("reset_busy", 128'(busy_vec), Z);
    chk("reset_cnt", 128'(commit_cnt), Z);
    chk("reset_stall", 128'(stall), Z);

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_stall", i), 128'(stall), 128'(vecs[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e_rs1);
      chk($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e_rs2);
      chk($sformatf("vec%0d_busy", i), 128'(busy_vec), 128'(vecs[i].e_busy));
      chk($sformatf("vec%0d_cnt", i), 128'(commit_cnt), 128'(vecs[i].e_cnt));
    end

    // Sync the model with a reset, then saturate the 4-bit counter
    drive(idle);
    reset = 1'b1;
    model_step();
    for (int i = 0; i < 20; i++) begin
      drive(idle);
      wb_regwrite_in = 1'b1;
      wb_memtoreg_in = 1'($urandom_range(0, 1));
      wb_rd_in       = 5'($urandom_range(1, 31));
      wb_dm_in       = {$urandom, $urandom, $urandom, $urandom};
      wb_alu_in      = {$urandom, $urandom, $urandom, $urandom};
      model_step();
      chk("sat_cnt4", 128'(commit_cnt_s), 128'((i + 1 > 15) ? 15 : i + 1));
    end
    chk("sat_cnt16", 128'(commit_cnt), 128'(20));

    // Randomized traffic on a narrow address range so hazards and bypasses are frequent
    for (int i = 0; i < 1500; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      wb_regwrite_in = 1'($urandom_range(0, 1));
      wb_memtoreg_in = 1'($urandom_range(0, 1));
      wb_rd_in       = 5'($urandom_range(0, 7));
      wb_dm_in       = {$urandom, $urandom, $urandom, $urandom};
      wb_alu_in      = {$urandom, $urandom, $urandom, $urandom};
      rs1_addr       = 5'($urandom_range(0, 7));
      rs2_addr       = 5'($urandom_range(0, 7));
      rd_en          = 1'($urandom_range(0, 1));
      issue_valid    = 1'($urandom_range(0, 1));
      issue_rd       = 5'($urandom_range(0, 7));
      issue_regwrite = 1'($urandom_range(0, 1));
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
